// File: rtl/leiwand_rv32_mem_bridge.sv
// Byte-serialising load/store bridge: one 32-bit core access becomes 1, 2 or 4 byte-RAM bus cycles.
// Optional build macro LEIWAND_RV32_MEM_BRIDGE_MISALIGN_TRAP_EN rejects misaligned half/word requests via o_err.
module leiwand_rv32_mem_bridge #(
    parameter int unsigned BUS_ADDR_W = 5,
    parameter int unsigned BYTE_W     = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req,
    input  logic [31:0]           i_addr,
    input  logic                  i_we,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata,
    output logic                  o_done,
    output logic                  o_busy,
    output logic                  o_err,
    output logic                  o_bus_cyc,
    output logic                  o_bus_stb,
    output logic                  o_bus_we,
    output logic [BUS_ADDR_W-1:0] o_bus_addr,
    output logic [BYTE_W-1:0]     o_bus_dat,
    input  logic [BYTE_W-1:0]     i_bus_dat,
    input  logic                  i_bus_ack,
    input  logic                  i_bus_stall
);

    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RDY = 3'd1,
        STB      = 3'd2,
        WAIT_ACK = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            k_q, k_d;
    logic [1:0]            last_q, last_d;
    logic [1:0]            size_q, size_d;
    logic [BUS_ADDR_W-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic                  uns_q, uns_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     rbuf_q, rbuf_d;

    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic                  cyc_q, cyc_d;
    logic                  stb_q, stb_d;
    logic                  bwe_q, bwe_d;
    logic [BUS_ADDR_W-1:0] baddr_q, baddr_d;
    logic [BYTE_W-1:0]     bdat_q, bdat_d;

    logic                  misalign_c;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^i_addr[31:BUS_ADDR_W];

`ifdef LEIWAND_RV32_MEM_BRIDGE_MISALIGN_TRAP_EN
    // Size 3 is treated as word, so i_size[1] covers both word encodings.
    assign misalign_c = ((i_size == 2'd1) && i_addr[0]) ||
                        (i_size[1] && (i_addr[1:0] != 2'b00));
`else
    assign misalign_c = 1'b0;
`endif

    // Sign/zero extension of the assembled load bytes.
    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] raw,
                                                 input logic [1:0]        size,
                                                 input logic              uns);
        logic [DATA_W-1:0] res;
        case (size)
            2'd0:    res = uns ? {24'h000000, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            2'd1:    res = uns ? {16'h0000, raw[15:0]}   : {{16{raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            last_q  <= '0;
            size_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            rbuf_q  <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            bwe_q   <= 1'b0;
            baddr_q <= '0;
            bdat_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            last_q  <= last_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            bwe_q   <= bwe_d;
            baddr_q <= baddr_d;
            bdat_q  <= bdat_d;
        end
    end

    // Next-state and next-output logic; outputs are computed together with the state they belong to.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        last_d  = last_q;
        size_d  = size_q;
        addr_d  = addr_q;
        we_d    = we_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        rbuf_d  = rbuf_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        err_d   = 1'b0;
        cyc_d   = cyc_q;
        stb_d   = 1'b0;
        bwe_d   = bwe_q;
        baddr_d = baddr_q;
        bdat_d  = bdat_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                cyc_d  = 1'b0;
                if (i_req && misalign_c) begin
                    err_d = 1'b1;
                end else if (i_req) begin
                    addr_d  = i_addr[BUS_ADDR_W-1:0];
                    we_d    = i_we;
                    uns_d   = i_unsigned;
                    size_d  = (i_size == 2'd3) ? 2'd2 : i_size;
                    wdata_d = i_wdata;
                    k_d     = 2'd0;
                    rbuf_d  = '0;
                    case (i_size)
                        2'd0:    last_d = 2'd0;
                        2'd1:    last_d = 2'd1;
                        default: last_d = 2'd3;
                    endcase
                    busy_d  = 1'b1;
                    cyc_d   = 1'b1;
                    bwe_d   = i_we;
                    baddr_d = i_addr[BUS_ADDR_W-1:0];
                    bdat_d  = i_wdata[BYTE_W-1:0];
                    if (!i_bus_stall) begin
                        state_d = STB;
                        stb_d   = 1'b1;
                    end else begin
                        state_d = WAIT_RDY;
                    end
                end
            end
            WAIT_RDY: begin
                cyc_d = 1'b1;
                if (!i_bus_stall) begin
                    state_d = STB;
                    stb_d   = 1'b1;
                end
            end
            STB: begin
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (i_bus_ack) begin
                    if (!we_q) begin
                        rbuf_d[{k_q, 3'b000} +: BYTE_W] = i_bus_dat;
                    end
                    if (k_q == last_q) begin
                        state_d = DONE;
                        cyc_d   = 1'b0;
                        done_d  = 1'b1;
                        if (!we_q) begin
                            rdata_d = extend(rbuf_d, size_q, uns_q);
                        end
                    end else begin
                        // Back-to-back strobe: the slave is idle with stall low in its ack cycle.
                        k_d     = k_q + 2'd1;
                        state_d = STB;
                        stb_d   = 1'b1;
                        baddr_d = addr_q + BUS_ADDR_W'(k_d);
                        bdat_d  = wdata_q[{k_d, 3'b000} +: BYTE_W];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_rdata    = rdata_q;
    assign o_done     = done_q;
    assign o_busy     = busy_q;
    assign o_err      = err_q;
    assign o_bus_cyc  = cyc_q;
    assign o_bus_stb  = stb_q;
    assign o_bus_we   = bwe_q;
    assign o_bus_addr = baddr_q;
    assign o_bus_dat  = bdat_q;

endmodule

// File: tb/tb_leiwand_rv32_mem_bridge.sv
// Directed bench for leiwand_rv32_mem_bridge with a behavioural 32-byte RAM (init stall, one-cycle-delayed ack).
module tb_leiwand_rv32_mem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        busy;
    logic        err;
    logic        bus_cyc;
    logic        bus_stb;
    logic        bus_we;
    logic [4:0]  bus_addr;
    logic [7:0]  bus_dat;
    logic [7:0]  bus_rdat;
    logic        bus_ack;
    logic        bus_stall;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    leiwand_rv32_mem_bridge #(.BUS_ADDR_W(5), .BYTE_W(8)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req),
        .i_addr      (addr),
        .i_we        (we),
        .i_size      (size),
        .i_unsigned  (uns),
        .i_wdata     (wdata),
        .o_rdata     (rdata),
        .o_done      (done),
        .o_busy      (busy),
        .o_err       (err),
        .o_bus_cyc   (bus_cyc),
        .o_bus_stb   (bus_stb),
        .o_bus_we    (bus_we),
        .o_bus_addr  (bus_addr),
        .o_bus_dat   (bus_dat),
        .i_bus_dat   (bus_rdat),
        .i_bus_ack   (bus_ack),
        .i_bus_stall (bus_stall)
    );

    // RAM model: stalls 6 cycles after reset, samples cyc&stb, acks one cycle later.
    logic [7:0]  mem [32] = '{default: 8'h00};
    int unsigned init_cnt;
    logic        ram_p1;
    logic        ram_pwe;
    logic [4:0]  ram_pa;
    logic [7:0]  ram_pd;

    assign bus_stall = (init_cnt != 0);

    always @(posedge clk) begin
        if (rst) begin
            init_cnt <= 6;
            ram_p1   <= 1'b0;
            bus_ack  <= 1'b0;
            bus_rdat <= 8'h00;
        end else begin
            if (init_cnt != 0) init_cnt <= init_cnt - 1;
            ram_p1  <= bus_cyc && bus_stb && !bus_stall;
            ram_pa  <= bus_addr;
            ram_pwe <= bus_we;
            ram_pd  <= bus_dat;
            bus_ack <= ram_p1;
            if (ram_p1) begin
                if (ram_pwe) mem[ram_pa] <= ram_pd;
                bus_rdat <= mem[ram_pa];
            end
        end
    end

    // Bus monitor: strobe log and event counters.
    logic [4:0] log_addr [8];
    logic [7:0] log_dat  [8];
    int log_n     = 0;
    int stb_total = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    int cyc_cnt   = 0;

    always @(posedge clk) begin
        if (!rst) begin
            if (bus_cyc && bus_stb) begin
                if (log_n < 8) begin
                    log_addr[log_n] = bus_addr;
                    log_dat[log_n]  = bus_dat;
                end
                log_n++;
                stb_total++;
            end
            if (done)    done_cnt++;
            if (err)     err_cnt++;
            if (bus_cyc) cyc_cnt++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one request and wait (bounded) for o_done; lat counts negedges after the accept edge.
    task automatic run_op(input logic op_we, input logic [1:0] op_size, input logic op_uns,
                          input logic [31:0] op_addr, input logic [31:0] op_wdata,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        req   = 1'b1;
        we    = op_we;
        size  = op_size;
        uns   = op_uns;
        addr  = op_addr;
        wdata = op_wdata;
        log_n = 0;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res = rdata;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t        vecs [16];
    logic [31:0] res;
    int          lat;
    int          nb;
    int          wait_n;
    int          snap_stb;
    int          snap_done;

    initial begin
        //            we    size  uns   addr           wdata          exp_rdata      lat
        vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0004, 32'h0,         32'hDEADBEEF, 13};
        vecs[1]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0004, 32'h0,         32'hFFFFFFEF,  4};
        vecs[2]  = '{1'b0, 2'd0, 1'b1, 32'hFFFF_FFE4, 32'h0,         32'h000000EF,  4};
        vecs[3]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0006, 32'h0,         32'hFFFFDEAD,  7};
        vecs[4]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0006, 32'h0,         32'h0000DEAD,  7};
        vecs[5]  = '{1'b1, 2'd2, 1'b0, 32'h0000_001E, 32'h11223344,  32'h0000DEAD, 13};
        vecs[6]  = '{1'b0, 2'd2, 1'b0, 32'h0000_001E, 32'h0,         32'h11223344, 13};
        vecs[7]  = '{1'b0, 2'd0, 1'b0, 32'h0000_001F, 32'h0,         32'h00000033,  4};
        vecs[8]  = '{1'b0, 2'd3, 1'b0, 32'h0000_0004, 32'h0,         32'hDEADBEEF, 13};
        vecs[9]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0000, 32'h0,         32'h00001122,  7};
        vecs[10] = '{1'b1, 2'd0, 1'b0, 32'h0000_0008, 32'hAAAAAA80,  32'h00001122,  4};
        vecs[11] = '{1'b0, 2'd0, 1'b0, 32'h0000_0008, 32'h0,         32'hFFFFFF80,  4};
        vecs[12] = '{1'b1, 2'd1, 1'b0, 32'h0000_000A, 32'h1234ABCD,  32'hFFFFFF80,  7};
        vecs[13] = '{1'b0, 2'd1, 1'b0, 32'h0000_000A, 32'h0,         32'hFFFFABCD,  7};
        vecs[14] = '{1'b0, 2'd1, 1'b1, 32'h0000_0008, 32'h0,         32'h00000080,  7};
        vecs[15] = '{1'b0, 2'd2, 1'b1, 32'h0000_0008, 32'h0,         32'hABCD0080, 13};

        rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0; uns = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset outputs",
              64'({rdata, done, busy, err, bus_cyc, bus_stb, bus_we, bus_addr, bus_dat}), 64'h0);

        // Word store issued straight out of reset while the RAM is still initialising.
        rst   = 1'b0;
        req   = 1'b1; we = 1'b1; size = 2'd2; uns = 1'b0;
        addr  = 32'h4; wdata = 32'hDEADBEEF; log_n = 0;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        check("wait_rdy cyc/stb/busy", 64'({bus_cyc, bus_stb, busy}), 64'b101);
        wait_n = 1;
        while (!done && wait_n < 200) begin
            @(negedge clk);
            wait_n++;
        end
        check("init store done", 64'(done), 64'h1);
        @(negedge clk);
        check("init store done pulse width", 64'({done, busy}), 64'b00);
        check("init store done count", 64'(done_cnt), 64'd1);
        check("init store ram bytes", 64'({mem[7], mem[6], mem[5], mem[4]}), 64'hDEADBEEF);

        foreach (vecs[i]) begin
            run_op(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, res, lat);
            nb = (vecs[i].size == 2'd0) ? 1 : (vecs[i].size == 2'd1) ? 2 : 4;
            check($sformatf("vec%0d rdata", i), 64'(res), 64'(vecs[i].exp_rdata));
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("vec%0d strobes", i), 64'(log_n), 64'(nb));
            for (int j = 0; j < nb; j++) begin
                check($sformatf("vec%0d addr%0d", i, j), 64'(log_addr[j]), 64'(5'(vecs[i].addr + 32'(j))));
                if (vecs[i].we)
                    check($sformatf("vec%0d dat%0d", i, j), 64'(log_dat[j]), 64'(8'(vecs[i].wdata >> (8 * j))));
            end
        end
        check("wrap store ram bytes", 64'({mem[30], mem[31], mem[0], mem[1]}), 64'h44332211);

        // Reset during the WAIT_ACK of the second byte of a word store.
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'd2; uns = 1'b0; addr = 32'hC; wdata = 32'hCAFEF00D; log_n = 0;
        @(posedge clk);
        @(negedge clk);
        req    = 1'b0;
        wait_n = 0;
        while (log_n < 2 && wait_n < 100) begin
            @(negedge clk);
            wait_n++;
        end
        check("mid-op reached byte 2", 64'(log_n), 64'd2);
        snap_done = done_cnt;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid-op reset outputs",
              64'({rdata, done, busy, err, bus_cyc, bus_stb, bus_we, bus_addr, bus_dat}), 64'h0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("mid-op reset no done", 64'(done_cnt), 64'(snap_done));
        run_op(1'b0, 2'd0, 1'b0, 32'h4, 32'h0, res, lat);
        check("post-reset byte load rdata", 64'(res), 64'hFFFFFFEF);
        check("post-reset byte load latency", 64'(lat), 64'd4);

        // A second request while busy must be ignored.
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'd2; uns = 1'b0; addr = 32'h4; log_n = 0;
        snap_stb  = stb_total;
        snap_done = done_cnt;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        req = 1'b1; addr = 32'h14; size = 2'd0;
        @(negedge clk);
        req    = 1'b0;
        wait_n = 0;
        while (!done && wait_n < 100) begin
            @(negedge clk);
            wait_n++;
        end
        check("busy-req load rdata", 64'(rdata), 64'hDEADBEEF);
        repeat (10) @(negedge clk);
        check("busy-req strobe count", 64'(stb_total - snap_stb), 64'd4);
        check("busy-req done count", 64'(done_cnt - snap_done), 64'd1);

`ifdef LEIWAND_RV32_MEM_BRIDGE_MISALIGN_TRAP_EN
        // Misaligned half load is trapped without touching the bus.
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'd1; uns = 1'b0; addr = 32'h5;
        snap_stb  = cyc_cnt;
        snap_done = done_cnt;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        check("misalign err/busy/done", 64'({err, busy, done}), 64'b100);
        @(negedge clk);
        check("misalign err pulse width", 64'(err), 64'h0);
        repeat (8) @(negedge clk);
        check("misalign no cyc", 64'(cyc_cnt - snap_stb), 64'd0);
        check("misalign no done", 64'(done_cnt - snap_done), 64'd0);
        check("misalign rdata held", 64'(rdata), 64'hDEADBEEF);
        run_op(1'b0, 2'd1, 1'b0, 32'h6, 32'h0, res, lat);
        check("aligned half after trap", 64'(res), 64'hFFFFDEAD);
        check("aligned half latency", 64'(lat), 64'd7);
`else
        // Without the trap a misaligned half load is performed bytewise.
        snap_done = err_cnt;
        run_op(1'b0, 2'd1, 1'b0, 32'h5, 32'h0, res, lat);
        check("misaligned half rdata", 64'(res), 64'hFFFFADBE);
        check("misaligned half latency", 64'(lat), 64'd7);
        check("misaligned half no err", 64'(err_cnt - snap_done), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/leiwand_rv32_mem_bridge.md
Name: leiwand_rv32_mem_bridge

Overview:
Upstream master for the 8-bit byte RAM. It converts one 32-bit core load/store request (byte, half or word) into 1, 2 or 4 sequential single-byte bus cycles using the RAM's stall/strobe/ack protocol. It assembles read bytes little-endian and sign- or zero-extends the result. It sits between the rv32 load/store path and the RAM.

Parameters:
BUS_ADDR_W, 5, width of the byte-RAM address bus (RAM holds 2^BUS_ADDR_W bytes).
BYTE_W, 8, bus data width; fixed at 8, any other value is unsupported.

Ports:
i_clk  in  1  clock
i_rst  in  1  reset
i_req  in  1  core request strobe; sampled only in IDLE
i_addr  in  32  byte address; only [BUS_ADDR_W-1:0] is used
i_we  in  1  1 = store, 0 = load
i_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word)
i_unsigned  in  1  1 = zero-extend load, 0 = sign-extend load
i_wdata  in  32  store data
o_rdata  out  32  load result, valid while o_done=1 and held until the next accept
o_done  out  1  one-cycle completion pulse
o_busy  out  1  high from the accept edge until o_done
o_err  out  1  one-cycle misalignment reject pulse (optional feature only, else tied 0)
o_bus_cyc  out  1  bus cycle
o_bus_stb  out  1  bus strobe
o_bus_we  out  1  bus write enable
o_bus_addr  out  BUS_ADDR_W  bus byte address
o_bus_dat  out  8  bus write data
i_bus_dat  in  8  bus read data
i_bus_ack  in  1  bus acknowledge
i_bus_stall  in  1  bus stall

Behaviour:
- Reset: i_rst and i_clk as already decided (i_rst synchronous, active-high; clock i_clk). Reset drives every output to 0, the state to IDLE and the byte counter to 0. A reset mid-operation abandons the transfer with no o_done. The RAM shares the same reset.
- All outputs are registered.
- States: IDLE, WAIT_RDY, STB, WAIT_ACK, DONE.
- IDLE:
  - o_busy=0, o_cyc=0, o_stb=0.
  - On i_req=1, latch addr, we, size, unsigned, wdata; N = 1/2/4 bytes; byte index k = 0; o_busy <= 1.
  - Next state is STB if i_bus_stall=0, else WAIT_RDY.
- WAIT_RDY: o_cyc=1, o_stb=0. Hold until i_bus_stall sampled 0, then go to STB. This covers the RAM's post-reset initialisation.
- STB:
  - o_cyc=1, o_stb=1 for exactly one cycle.
  - o_bus_addr = (addr + k) mod 2^BUS_ADDR_W, so the address wraps at the top of the RAM.
  - o_bus_we = we; o_bus_dat = wdata[8k+7:8k].
  - Next state is WAIT_ACK unconditionally; the slave samples cyc&stb on this edge.
- WAIT_ACK:
  - o_cyc=1, o_stb=0; addr, we and dat held stable.
  - On i_bus_ack=1, a load captures i_bus_dat into byte lane k.
  - If k = N-1, go to DONE; else k <= k+1 and go straight to STB. The slave is idle with stall low in its ack cycle.
  - No timeout.
- DONE:
  - o_cyc=0, o_done=1 for one cycle, o_busy <= 0 on the next edge, return to IDLE.
  - o_rdata is the assembled value: byte signed = {24{b7}, b}, half signed = {16{h15}, h}, otherwise zero-extended.
  - Stores leave o_rdata unchanged.
- Latency with the slave ready: 3 edges per byte. o_done is visible 3N+1 cycles after the accept edge: byte 4, half 7, word 13.
- i_req while busy is ignored; no queuing.
- Misaligned accesses without the optional feature are performed bytewise, with address wrap applying.

Optional Feature:
LEIWAND_RV32_MEM_BRIDGE_MISALIGN_TRAP_EN
- Defined:
  - A request with size=half and addr[0]=1, or size=word and addr[1:0]!=0, is rejected in IDLE.
  - No bus cycle is issued.
  - o_err pulses 1 for one cycle on the edge after i_req; o_done stays 0 and o_busy stays 0.
  - o_rdata is unchanged.
- Undefined: o_err is tied 0 and misaligned accesses complete normally.

Test Plan:
1. Reset, then immediately issue a word store of 0xDEADBEEF at addr 4 while the RAM is still initialising → bridge holds in WAIT_RDY; RAM bytes 4..7 = EF, BE, AD, DE; o_done pulses once.
2. Word load at addr 4 with the slave ready → o_rdata=0xDEADBEEF; o_done 13 cycles after accept; exactly 4 stb pulses at addr 4, 5, 6, 7.
3. Byte signed load at addr 4 → 0xFFFFFFEF. Byte unsigned at addr 4 → 0x000000EF. Half signed at addr 6 → 0xFFFFDEAD. Half unsigned at addr 6 → 0x0000DEAD.
4. Word store of 0x11223344 at addr 30 (BUS_ADDR_W=5), macro undefined → bus addrs 30, 31, 0, 1 receive 44, 33, 22, 11; a word load at 30 returns 0x11223344.
5. i_rst asserted during WAIT_ACK of byte 2 of a word store → all outputs 0 next cycle; no o_done; a subsequent byte load completes normally. Also: a second i_req while busy produces no extra bus cycles.
6. Macro defined: half load at addr 5 → o_err=1 for one cycle; o_bus_cyc never asserted; o_done=0. An aligned half load at addr 6 then succeeds.
